// File: rtl/control_unit.sv
// Fetch/decode front end: combinational instruction memory with a program-load port,
// main control decode and immediate generation for the IF/ID stage.
module control_unit #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    input  logic [31:0] dec_instr,
    output logic [31:0] imm_ext,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic        RegWrite,
    output logic [1:0]  ALUOp
);

    localparam int AW = $clog2(IMEM_DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Control word order: {ALUSrc,MemtoReg,MemRead,MemWrite,Branch,RegWrite,ALUOp[1:0]}
    localparam logic [7:0] CTRL_R      = 8'b0000_0110;
    localparam logic [7:0] CTRL_I_ALU  = 8'b1000_0111;
    localparam logic [7:0] CTRL_LOAD   = 8'b1110_0100;
    localparam logic [7:0] CTRL_STORE  = 8'b1001_0000;
    localparam logic [7:0] CTRL_BRANCH = 8'b0000_1001;
    localparam logic [7:0] CTRL_BUBBLE = 8'b0000_0000;

    // Contents survive rst; only the load port ever changes them.
    logic [31:0] r_mem [IMEM_DEPTH] = '{default: NOP_WORD};

    logic          w_pc_in_range;
    logic          w_waddr_in_range;
    logic [AW-1:0] w_rd_idx;
    logic [AW-1:0] w_wr_idx;
    logic          w_wr_en;
    logic [6:0]    w_opcode;
    logic [7:0]    w_ctrl;
    logic [31:0]   w_imm;
    logic          w_unused_bits;

    assign w_pc_in_range    = (pc[31:AW+2] == '0);
    assign w_waddr_in_range = (imem_waddr[31:AW+2] == '0);
    assign w_rd_idx         = pc[AW+1:2];
    assign w_wr_idx         = imem_waddr[AW+1:2];
    assign w_wr_en          = imem_we && !rst && w_waddr_in_range;
    assign w_unused_bits    = &{1'b0, pc[1:0], imem_waddr[1:0]};

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= imem_wdata;
        end
    end

    // Out-of-range fetches must not alias onto low words.
    assign instr = (rst || !w_pc_in_range) ? NOP_WORD : r_mem[w_rd_idx];

    assign w_opcode = dec_instr[6:0];

    always_comb begin
        w_ctrl = CTRL_BUBBLE;
        case (w_opcode)
            OP_R:      w_ctrl = CTRL_R;
            OP_I_ALU:  w_ctrl = CTRL_I_ALU;
            OP_LOAD:   w_ctrl = CTRL_LOAD;
            OP_STORE:  w_ctrl = CTRL_STORE;
            OP_BRANCH: w_ctrl = CTRL_BRANCH;
            default:   w_ctrl = CTRL_BUBBLE;
        endcase
    end

    always_comb begin
        w_imm = 32'h0;
        case (w_opcode)
            OP_LOAD, OP_I_ALU, OP_JALR:
                w_imm = {{20{dec_instr[31]}}, dec_instr[31:20]};
            OP_STORE:
                w_imm = {{20{dec_instr[31]}}, dec_instr[31:25], dec_instr[11:7]};
            OP_BRANCH:
                w_imm = {{19{dec_instr[31]}}, dec_instr[31], dec_instr[7],
                         dec_instr[30:25], dec_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm = {dec_instr[31:12], 12'h000};
            OP_JAL:
                w_imm = {{11{dec_instr[31]}}, dec_instr[31], dec_instr[19:12],
                         dec_instr[20], dec_instr[30:21], 1'b0};
            default:
                w_imm = 32'h0;
        endcase
    end

    assign imm_ext  = w_imm;
    assign ALUSrc   = w_ctrl[7];
    assign MemtoReg = w_ctrl[6];
    assign MemRead  = w_ctrl[5];
    assign MemWrite = w_ctrl[4];
    assign Branch   = w_ctrl[3];
    assign RegWrite = w_ctrl[2];
    assign ALUOp    = w_ctrl[1:0];

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table-driven decode vectors and memory sequences,
// all checked through an expected-value queue.
module tb_control_unit;

    localparam int          DEPTH = 256;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] dec_instr;
    logic [31:0] imm_ext;
    logic        ALUSrc, MemtoReg, MemRead, MemWrite, Branch, RegWrite;
    logic [1:0]  ALUOp;

    always #5 clk = ~clk;

    control_unit #(.IMEM_DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dec_instr(dec_instr), .imm_ext(imm_ext),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .RegWrite(RegWrite), .ALUOp(ALUOp)
    );

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [7:0]  ctrl;
        logic [31:0] imm;
    } dec_vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    logic [31:0] model_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic sb_push(input string nm, input logic [31:0] e);
        sb_item_t it;
        it.name = nm;
        it.exp  = e;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_item_t it;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h with nothing expected", act);
        end else begin
            it = sb_q.pop_front();
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    endtask

    function automatic logic [31:0] exp_fetch(input logic [31:0] a);
        if (rst || a >= 32'(4 * DEPTH)) return NOP;
        return model_mem[a[AW+1:2]];
    endfunction

    task automatic fetch(input logic [31:0] a, input string nm);
        @(posedge clk); #1;
        pc = a;
        sb_push(nm, exp_fetch(a));
        @(negedge clk);
        sb_pop(instr);
    endtask

    // Read-before-write checked at the negedge, new contents checked just after the edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string nm);
        @(posedge clk); #1;
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        pc         = a;
        sb_push({nm, "_pre_edge"}, exp_fetch(a));
        @(negedge clk);
        sb_pop(instr);
        @(posedge clk);
        if (!rst && a < 32'(4 * DEPTH)) model_mem[a[AW+1:2]] = d;
        #1;
        imem_we = 1'b0;
        sb_push({nm, "_post_edge"}, exp_fetch(a));
        sb_pop(instr);
    endtask

    task automatic decode_check(input dec_vec_t v);
        @(posedge clk); #1;
        dec_instr = v.word;
        sb_push({v.name, "_ctrl"}, {24'h0, v.ctrl});
        sb_push({v.name, "_imm"}, v.imm);
        @(negedge clk);
        sb_pop({24'h0, ALUSrc, MemtoReg, MemRead, MemWrite, Branch, RegWrite, ALUOp});
        sb_pop(imm_ext);
    endtask

    dec_vec_t vecs[$];

    initial begin
        // ctrl = {ALUSrc,MemtoReg,MemRead,MemWrite,Branch,RegWrite,ALUOp}
        vecs.push_back('{"addi_x1_5",   32'h0050_0093, 8'b1000_0111, 32'h0000_0005});
        vecs.push_back('{"lw_neg4",     32'hFFC0_A103, 8'b1110_0100, 32'hFFFF_FFFC});
        vecs.push_back('{"sw_8",        32'h0020_A423, 8'b1001_0000, 32'h0000_0008});
        vecs.push_back('{"beq_neg8",    32'hFE20_8CE3, 8'b0000_1001, 32'hFFFF_FFF8});
        vecs.push_back('{"add",         32'h0020_81B3, 8'b0000_0110, 32'h0000_0000});
        vecs.push_back('{"lui",         32'h1234_50B7, 8'b0000_0000, 32'h1234_5000});
        vecs.push_back('{"auipc",       32'hFFFF_F097, 8'b0000_0000, 32'hFFFF_F000});
        vecs.push_back('{"jal_8",       32'h0080_006F, 8'b0000_0000, 32'h0000_0008});
        vecs.push_back('{"jal_signbit", 32'h8000_006F, 8'b0000_0000, 32'hFFF0_0000});
        vecs.push_back('{"jalr_neg16",  32'hFF00_80E7, 8'b0000_0000, 32'hFFFF_FFF0});
        vecs.push_back('{"addi_min",    32'h8000_0013, 8'b1000_0111, 32'hFFFF_F800});
        vecs.push_back('{"sw_neg1",     32'hFE11_2FA3, 8'b1001_0000, 32'hFFFF_FFFF});
        vecs.push_back('{"bad_opcode",  32'hFFFF_FFFF, 8'b0000_0000, 32'h0000_0000});

        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        rst        = 1'b1;
        pc         = 32'h0;
        imem_we    = 1'b0;
        imem_waddr = 32'h0;
        imem_wdata = 32'h0;
        dec_instr  = 32'h0;

        repeat (2) @(posedge clk);
        fetch(32'h0, "reset_instr");

        // Writes are blocked under reset.
        do_write(32'h4, 32'hDEAD_BEEF, "wr_during_rst");
        fetch(32'h4, "rst_pc4");
        @(posedge clk); #1;
        rst = 1'b0;
        fetch(32'h4, "after_rst_pc4_dropped");

        do_write(32'h0, 32'h0050_0093, "load_word0");
        fetch(32'h0, "fetch_word0");
        fetch(32'h2, "fetch_low_bits_ignored");

        foreach (vecs[i]) decode_check(vecs[i]);

        // Out-of-range writes must not land anywhere.
        do_write(32'(4 * DEPTH), 32'hCAFE_F00D, "wr_oob");
        fetch(32'h0, "word0_after_oob");
        fetch(32'(4 * DEPTH), "fetch_oob");
        do_write(32'h8000_0000, 32'h1111_1111, "wr_far_oob");
        fetch(32'h8000_0000, "fetch_far_oob");

        do_write(32'h4, 32'h0000_0004 ^ $urandom, "wr_w1");
        do_write(32'h200, $urandom, "wr_mid");
        do_write(32'(4 * DEPTH - 4), $urandom, "wr_last");
        do_write(32'h8, 32'hA5A5_5A5A, "wr_w2");
        do_write(32'h8, 32'h5A5A_A5A5, "rewr_w2");

        // Reset masks fetch but not decode, and release is immediate.
        @(posedge clk); #1;
        rst       = 1'b1;
        pc        = 32'h0;
        dec_instr = 32'hFFC0_A103;
        sb_push("rst_masks_fetch", NOP);
        sb_push("rst_keeps_decode", 32'h0000_00E4);
        @(negedge clk);
        sb_pop(instr);
        sb_pop({24'h0, ALUSrc, MemtoReg, MemRead, MemWrite, Branch, RegWrite, ALUOp});
        rst = 1'b0;
        #1;
        sb_push("rst_release_same_cycle", model_mem[0]);
        sb_pop(instr);

        for (int a = 0; a < DEPTH; a++) fetch(32'(4 * a), "readback");

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule
